sync_q_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one synchronous queue between `NREQ` requesters, e.g. instruction-fetch and load/store request paths feeding a common memory request queue. It picks one valid requester per cycle, forwards its beat to the queue write port when the queue has room, and tags the beat with the source index. With packet locking compiled in, it holds the grant on one requester until that requester's last beat.

---
 rtl/sync_q_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_sync_q_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_q_wr_arbiter.sv
// sync_q_wr_arbiter: round-robin write-side arbiter sharing one synchronous queue
// between NREQ requesters. The winning beat is forwarded combinationally to the
// queue write port, tagged with its source index in the upper IDW bits.
// Optional macro SYNC_Q_ARB_LOCK_EN: once a requester's first beat is accepted,
// the grant stays on that requester until its req_last beat is accepted.
module sync_q_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 31,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  q_wen,
    output logic [WIDTH+IDW-1:0]  q_wdata,
    input  logic                  q_wok,
    input  logic                  q_flush,
    output logic [IDW-1:0]        grant_id,
    output logic                  locked
);

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             search_vld;
    logic [IDW-1:0]   search_idx;
    logic             win_vld;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_data;
    logic [IDW-1:0]   ptr_inc;
    int               cand;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        search_vld = 1'b0;
        search_idx = '0;
        cand       = 0;
        // Walk downward so the closest requester to rr_ptr is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req_valid[IDW'(cand)]) begin
                search_vld = 1'b1;
                search_idx = IDW'(cand);
            end
        end
    end

`ifdef SYNC_Q_ARB_LOCK_EN
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           locked_q;

    // Winner selection: locked owner only while a packet is in flight.
    always_comb begin
        if (state_q == LOCKED) begin
            win_vld = req_valid[lock_id_q];
            win_idx = lock_id_q;
        end else begin
            win_vld = search_vld;
            win_idx = search_idx;
        end
    end

    // Next-state: flush wins over accept; an accepted non-last beat locks the owner.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (q_flush) begin
            state_d   = IDLE;
            rr_ptr_d  = '0;
            lock_id_d = '0;
        end else if (q_wen) begin
            rr_ptr_d = ptr_inc;
            if (req_last[win_idx]) begin
                state_d = IDLE;
            end else begin
                state_d   = LOCKED;
                lock_id_d = win_idx;
            end
        end
    end

    // FSM, pointer and owner registers with a registered locked flag.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            locked_q  <= (state_d == LOCKED);
        end
    end

    assign locked = locked_q;
`else
    logic unused_last;
    assign unused_last = ^req_last;

    // Winner selection: every beat arbitrated independently.
    always_comb begin
        win_vld = search_vld;
        win_idx = search_idx;
    end

    // Next pointer: flush clears, an accepted beat advances past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (q_flush) begin
            rr_ptr_d = '0;
        end else if (q_wen) begin
            rr_ptr_d = ptr_inc;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign locked = 1'b0;
`endif

    assign ptr_inc = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    assign q_wen   = win_vld & q_wok & ~q_flush;

    // Payload mux, ready decode and tagged write data for the winner.
    always_comb begin
        win_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_data     = req_data[i*WIDTH +: WIDTH];
                req_ready[i] = q_wen;
            end
        end
        q_wdata  = win_vld ? {win_idx, win_data} : '0;
        grant_id = win_vld ? win_idx : '0;
    end

endmodule

// File: tb/tb_sync_q_wr_arbiter.sv
// Directed bench for sync_q_wr_arbiter (NREQ=4 main instance, NREQ=3 wrap instance).
module tb_sync_q_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 31;
    localparam int IDW   = 2;

    logic                  CLK = 1'b0;
    logic                  RSTN;
    logic [NREQ-1:0]       req_valid, req_last, req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  q_wen, q_wok, q_flush, locked;
    logic [WIDTH+IDW-1:0]  q_wdata;
    logic [IDW-1:0]        grant_id;

    logic [2:0]  v3, l3, r3;
    logic [23:0] d3;
    logic        w3, wok3, fl3, lk3;
    logic [9:0]  wd3;
    logic [1:0]  g3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sync_q_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .q_wen(q_wen), .q_wdata(q_wdata),
        .q_wok(q_wok), .q_flush(q_flush), .grant_id(grant_id), .locked(locked)
    );

    sync_q_wr_arbiter #(.NREQ(3), .WIDTH(8)) dut3 (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(v3), .req_last(l3), .req_data(d3),
        .req_ready(r3), .q_wen(w3), .q_wdata(wd3),
        .q_wok(wok3), .q_flush(fl3), .grant_id(g3), .locked(lk3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pay(input int i);
        return 31'h1234_5000 + WIDTH'(i);
    endfunction

    // Expect an accepted beat from requester g on the main instance.
    task automatic beat(input string tag, input int g);
        logic [WIDTH+IDW-1:0] ew;
        logic [NREQ-1:0]      er;
        ew = {IDW'(g), pay(g)};
        er = 4'b0001 << g;
        #1;
        chk({tag, "_wen"},   q_wen, 1);
        chk({tag, "_gid"},   grant_id, g);
        chk({tag, "_ready"}, req_ready, er);
        chk({tag, "_wdata"}, q_wdata, ew);
    endtask

    initial begin
        RSTN      = 1'b0;
        req_valid = '0;
        req_last  = '1;
        q_wok     = 1'b1;
        q_flush   = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = pay(i);
        v3   = '0;
        l3   = '1;
        wok3 = 1'b1;
        fl3  = 1'b0;
        d3   = {8'hA2, 8'hA1, 8'hA0};

        // Reset state
        #12;
        chk("rst_wen",    q_wen, 0);
        chk("rst_ready",  req_ready, 0);
        chk("rst_gid",    grant_id, 0);
        chk("rst_wdata",  q_wdata, 0);
        chk("rst_locked", locked, 0);
        tick();
        RSTN = 1'b1;
        tick();

        // All valid: 0,1,2,3,0,1,2,3
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            beat($sformatf("rr%0d", i), i % 4);
            tick();
        end

        // Queue full stalls; pointer holds at 0
        q_wok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_wen", i),   q_wen, 0);
            chk($sformatf("stall%0d_ready", i), req_ready, 0);
            chk($sformatf("stall%0d_gid", i),   grant_id, 0);
            tick();
        end
        q_wok = 1'b1;
        beat("unstall", 0);
        tick();

        // Pointer at 1 -> winner 1, pointer 2; then sparse 1010: 3, 1, 3
        beat("pre_sparse", 1);
        tick();
        req_valid = 4'b1010;
        beat("sparse0", 3);
        tick();
        beat("sparse1", 1);
        tick();
        beat("sparse2", 3);
        tick();

        // Flush with all valid and pointer at 1
        req_valid = 4'b1111;
        beat("pre_flush", 0);
        tick();
        q_flush = 1'b1;
        #1;
        chk("flush_wen",   q_wen, 0);
        chk("flush_ready", req_ready, 0);
        tick();
        q_flush = 1'b0;
        beat("post_flush", 0);
        tick();

        // Async reset mid-run restarts arbitration at requester 0
        RSTN = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_gid",    grant_id, 0);
        tick();
        RSTN = 1'b1;
        beat("post_arst", 0);
        tick();

`ifdef SYNC_Q_ARB_LOCK_EN
        // Requester 1 sends three beats while requester 2 waits
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        beat("lk_b1", 1);
        chk("lk_b1_locked", locked, 0);
        tick();
        beat("lk_b2", 1);
        chk("lk_b2_locked", locked, 1);
        tick();
        req_last = 4'b0010;
        beat("lk_b3", 1);
        chk("lk_b3_locked", locked, 1);
        tick();
        req_last = 4'b1111;
        beat("lk_next", 2);
        chk("lk_next_locked", locked, 0);
        tick();

        // Flush while locked on requester 1
        req_last = 4'b0000;
        beat("lkf_b1", 1);
        tick();
        req_valid = 4'b1111;
        q_flush   = 1'b1;
        #1;
        chk("lkf_locked", locked, 1);
        chk("lkf_wen",    q_wen, 0);
        chk("lkf_ready",  req_ready, 0);
        tick();
        q_flush  = 1'b0;
        req_last = 4'b1111;
        beat("lkf_after", 0);
        chk("lkf_after_locked", locked, 0);
        tick();

        // Reset mid-packet drops the lock at once
        req_last = 4'b0000;
        beat("lkr_b1", 1);
        tick();
        #1;
        chk("lkr_locked", locked, 1);
        RSTN = 1'b0;
        #1;
        chk("lkr_rst_locked", locked, 0);
        tick();
        RSTN     = 1'b1;
        req_last = 4'b1111;
        beat("lkr_after", 0);
        tick();
`endif

        // NREQ=3 instance: pointer wraps 2 -> 0
        req_valid = '0;
        v3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            logic [9:0] e3;
            e3 = {2'(i % 3), 8'hA0 + 8'(i % 3)};
            #1;
            chk($sformatf("n3_%0d_wen", i),   w3, 1);
            chk($sformatf("n3_%0d_gid", i),   g3, i % 3);
            chk($sformatf("n3_%0d_wdata", i), wd3, e3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
